// File: rtl/oram_host_adapter_if.sv
// Bundles the host request/response channel and the TinyORAM core command/data channels.
// The adapter uses the slave view; whoever drives requests and models the core uses master.
interface oram_host_adapter_if #(
  parameter int ORAMB      = 512,
  parameter int ORAMU      = 32,
  parameter int FEDWidth   = 64,
  parameter int BECMDWidth = 2
) ();
  logic [BECMDWidth-1:0] HostCmd;
  logic [ORAMU-1:0]      HostAddr;
  logic [ORAMB-1:0]      HostData;
  logic                  HostValid;
  logic                  HostReady;
  logic [ORAMB-1:0]      HostRespData;
  logic                  HostRespValid;
  logic                  HostRespReady;
  logic [BECMDWidth-1:0] Cmd;
  logic [ORAMU-1:0]      PAddr;
  logic                  CmdValid;
  logic                  CmdReady;
  logic [FEDWidth-1:0]   DataIn;
  logic                  DataInValid;
  logic                  DataInReady;
  logic [FEDWidth-1:0]   DataOut;
  logic                  DataOutValid;
  logic                  DataOutReady;

  modport slave (
    input  HostCmd, HostAddr, HostData, HostValid, HostRespReady,
    input  CmdReady, DataInReady, DataOut, DataOutValid,
    output HostReady, HostRespData, HostRespValid,
    output Cmd, PAddr, CmdValid, DataIn, DataInValid, DataOutReady
  );

  modport master (
    output HostCmd, HostAddr, HostData, HostValid, HostRespReady,
    output CmdReady, DataInReady, DataOut, DataOutValid,
    input  HostReady, HostRespData, HostRespValid,
    input  Cmd, PAddr, CmdValid, DataIn, DataInValid, DataOutReady
  );
endinterface

// File: rtl/oram_host_adapter.sv
// Turns one whole-block host request into a core command plus FEDWidth-bit data beats,
// and gathers read beats back into a single block response. One request in flight at a time.
module oram_host_adapter #(
  parameter int ORAMB      = 512,
  parameter int ORAMU      = 32,
  parameter int FEDWidth   = 64,
  parameter int BECMDWidth = 2
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  oram_host_adapter_if.slave   io_bus
);
  localparam int NBeats = ORAMB / FEDWidth;
  localparam int BeatW  = $clog2(NBeats) + 1;
  localparam int IdxW   = (NBeats > 1) ? $clog2(NBeats) : 1;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(NBeats - 1);

  generate
    if (ORAMB % FEDWidth != 0) begin : g_widthCheck
      $fatal(1, "oram_host_adapter: ORAMB must be a multiple of FEDWidth");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, CMD, WDATA, RDATA, RESP} state_e;

  state_e                             r_state;
  logic [BeatW-1:0]                   r_beat;
  logic [BECMDWidth-1:0]              r_cmd;
  logic [ORAMU-1:0]                   r_addr;
  logic [NBeats-1:0][FEDWidth-1:0]    r_data;
  logic [NBeats-1:0][FEDWidth-1:0]    r_resp;
  logic                               r_hostReady;
  logic                               r_cmdValid;
  logic                               r_dataInValid;
  logic                               r_dataOutReady;
  logic                               r_respValid;
  logic [IdxW-1:0]                    w_beatIdx;

  // Packed beat arrays put beat 0 in the least significant FEDWidth bits of the block.
  assign w_beatIdx = r_beat[IdxW-1:0];

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_state        <= IDLE;
      r_beat         <= '0;
      r_cmd          <= '0;
      r_addr         <= '0;
      r_data         <= '0;
      r_resp         <= '0;
      r_hostReady    <= 1'b0;
      r_cmdValid     <= 1'b0;
      r_dataInValid  <= 1'b0;
      r_dataOutReady <= 1'b0;
      r_respValid    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_hostReady <= 1'b1;
          if (r_hostReady && io_bus.HostValid) begin
            r_cmd       <= io_bus.HostCmd;
            r_addr      <= io_bus.HostAddr;
            r_data      <= io_bus.HostData;
            r_hostReady <= 1'b0;
            r_cmdValid  <= 1'b1;
            r_state     <= CMD;
          end
        end
        CMD: begin
          if (io_bus.CmdReady) begin
            r_cmdValid <= 1'b0;
            if (!r_cmd[BECMDWidth-1]) begin
              r_dataInValid <= 1'b1;
              r_state       <= WDATA;
            end else begin
              r_dataOutReady <= 1'b1;
              r_state        <= RDATA;
            end
          end
        end
        WDATA: begin
          if (io_bus.DataInReady) begin
            if (r_beat == LastBeat) begin
              r_beat        <= '0;
              r_dataInValid <= 1'b0;
              r_hostReady   <= 1'b1;
              r_state       <= IDLE;
            end else begin
              r_beat <= r_beat + 1'b1;
            end
          end
        end
        RDATA: begin
          if (io_bus.DataOutValid) begin
            r_resp[w_beatIdx] <= io_bus.DataOut;
            if (r_beat == LastBeat) begin
              r_beat         <= '0;
              r_dataOutReady <= 1'b0;
              r_respValid    <= 1'b1;
              r_state        <= RESP;
            end else begin
              r_beat <= r_beat + 1'b1;
            end
          end
        end
        RESP: begin
          if (io_bus.HostRespReady) begin
            r_respValid <= 1'b0;
            r_hostReady <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign io_bus.HostReady     = r_hostReady;
  assign io_bus.HostRespData  = r_resp;
  assign io_bus.HostRespValid = r_respValid;
  assign io_bus.Cmd           = r_cmd;
  assign io_bus.PAddr         = r_addr;
  assign io_bus.CmdValid      = r_cmdValid;
  assign io_bus.DataIn        = r_data[w_beatIdx];
  assign io_bus.DataInValid   = r_dataInValid;
  assign io_bus.DataOutReady  = r_dataOutReady;
endmodule

// File: tb/tb_oram_host_adapter.sv
// Scoreboard bench for oram_host_adapter: host requests push expected commands, write beats
// and read responses; a negedge monitor pops and compares them as the DUT produces them.
module tb_oram_host_adapter;
  localparam int ORAMB      = 512;
  localparam int ORAMU      = 32;
  localparam int FEDWidth   = 64;
  localparam int BECMDWidth = 2;
  localparam int NBeats     = ORAMB / FEDWidth;
  localparam int CmdW       = BECMDWidth + ORAMU;

  typedef logic [ORAMB+7:0] word_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   numChecks = 0;
  int   numFails  = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  oram_host_adapter_if #(.ORAMB(ORAMB), .ORAMU(ORAMU), .FEDWidth(FEDWidth),
                         .BECMDWidth(BECMDWidth)) bus ();

  oram_host_adapter #(.ORAMB(ORAMB), .ORAMU(ORAMU), .FEDWidth(FEDWidth),
                      .BECMDWidth(BECMDWidth)) dut (
    .i_Clock (clock),
    .i_Reset (reset),
    .io_bus  (bus)
  );

  logic [CmdW-1:0]     expCmdQ[$];
  logic [FEDWidth-1:0] expBeatQ[$];
  logic [ORAMB-1:0]    expRespQ[$];

  int               cmdDelay  = 0;
  int               respDelay = 0;
  bit               dinRandom = 1'b0;
  bit               gapOut    = 1'b0;
  bit               outEnable = 1'b0;
  int               outIdx    = 0;
  logic [ORAMB-1:0] coreBlock = '0;
  int               dinHsCount = 0;

  task automatic checkOutput(input string tag, input word_t observed, input word_t expected);
    numChecks++;
    if (observed !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Core command acceptance, stalled cmdDelay cycles after CmdValid first appears.
  initial begin : cmdReadyDriver
    int waitCnt;
    waitCnt = 0;
    bus.CmdReady = 1'b0;
    forever begin
      @(posedge clock); #1;
      if (reset || !bus.CmdValid) begin
        waitCnt = 0;
        bus.CmdReady = 1'b0;
      end else begin
        bus.CmdReady = (waitCnt >= cmdDelay);
        waitCnt++;
      end
    end
  end

  initial begin : respReadyDriver
    int waitCnt;
    waitCnt = 0;
    bus.HostRespReady = 1'b0;
    forever begin
      @(posedge clock); #1;
      if (reset || !bus.HostRespValid) begin
        waitCnt = 0;
        bus.HostRespReady = 1'b0;
      end else begin
        bus.HostRespReady = (waitCnt >= respDelay);
        waitCnt++;
      end
    end
  end

  initial begin : dataInReadyDriver
    bus.DataInReady = 1'b0;
    forever begin
      @(posedge clock); #1;
      bus.DataInReady = dinRandom ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Streams coreBlock one beat at a time; valid is held until consumed, with an optional idle gap.
  initial begin : dataOutDriver
    bit hs;
    bus.DataOutValid = 1'b0;
    bus.DataOut      = '0;
    forever begin
      @(negedge clock);
      hs = bus.DataOutValid && bus.DataOutReady && !reset;
      @(posedge clock); #1;
      if (hs) outIdx++;
      if (outEnable && outIdx < NBeats && !(gapOut && hs)) begin
        bus.DataOutValid = 1'b1;
        bus.DataOut      = FEDWidth'(coreBlock >> (outIdx * FEDWidth));
      end else begin
        bus.DataOutValid = 1'b0;
      end
    end
  end

  int                  acceptCyc = 0;
  bit                  prevCmdValid, prevCmdStall, prevDinStall, prevRespStall;
  logic [CmdW-1:0]     prevCmdWord;
  logic [FEDWidth-1:0] prevDin;
  logic [ORAMB-1:0]    prevResp;
  int                  respWait = 0;

  always @(negedge clock) begin : monitor
    if (reset) begin
      prevCmdValid  = 1'b0;
      prevCmdStall  = 1'b0;
      prevDinStall  = 1'b0;
      prevRespStall = 1'b0;
      respWait      = 0;
    end else begin
      if (bus.HostValid && bus.HostReady) acceptCyc = cyc;
      if (bus.CmdValid && !prevCmdValid)
        checkOutput("cmdLatency", word_t'(cyc - acceptCyc), word_t'(1));
      if (prevCmdStall)
        checkOutput("cmdHold", word_t'({bus.CmdValid, bus.Cmd, bus.PAddr}), word_t'({1'b1, prevCmdWord}));
      if (bus.CmdValid && bus.CmdReady) begin
        checkOutput("cmdQueued", word_t'(expCmdQ.size() != 0), word_t'(1));
        if (expCmdQ.size() != 0)
          checkOutput("cmdWord", word_t'({bus.Cmd, bus.PAddr}), word_t'(expCmdQ.pop_front()));
      end
      if (prevDinStall)
        checkOutput("dinHold", word_t'({bus.DataInValid, bus.DataIn}), word_t'({1'b1, prevDin}));
      if (bus.DataInValid && bus.DataInReady) begin
        dinHsCount++;
        checkOutput("beatQueued", word_t'(expBeatQ.size() != 0), word_t'(1));
        if (expBeatQ.size() != 0)
          checkOutput("dataInBeat", word_t'(bus.DataIn), word_t'(expBeatQ.pop_front()));
      end
      if (prevRespStall)
        checkOutput("respHold", word_t'({bus.HostRespValid, bus.HostRespData}), word_t'({1'b1, prevResp}));
      if (bus.HostRespValid) begin
        if (bus.HostRespReady) begin
          checkOutput("respWait", word_t'(respWait), word_t'(respDelay));
          checkOutput("respQueued", word_t'(expRespQ.size() != 0), word_t'(1));
          if (expRespQ.size() != 0)
            checkOutput("respData", word_t'(bus.HostRespData), word_t'(expRespQ.pop_front()));
          respWait = 0;
        end else begin
          respWait++;
        end
      end
      prevCmdValid  = bus.CmdValid;
      prevCmdStall  = bus.CmdValid && !bus.CmdReady;
      prevCmdWord   = {bus.Cmd, bus.PAddr};
      prevDinStall  = bus.DataInValid && !bus.DataInReady;
      prevDin       = bus.DataIn;
      prevRespStall = bus.HostRespValid && !bus.HostRespReady;
      prevResp      = bus.HostRespData;
    end
  end

  task automatic applyStimulus(input logic [1:0] cmd, input logic [ORAMU-1:0] addr,
                               input logic [ORAMB-1:0] data, output int accCyc);
    bit accepted;
    accepted = 1'b0;
    accCyc   = 0;
    @(posedge clock); #2;
    bus.HostCmd   = cmd;
    bus.HostAddr  = addr;
    bus.HostData  = data;
    bus.HostValid = 1'b1;
    expCmdQ.push_back({cmd, addr});
    if (!cmd[1]) begin
      for (int k = 0; k < NBeats; k++) expBeatQ.push_back(FEDWidth'(data >> (k * FEDWidth)));
    end else begin
      expRespQ.push_back(coreBlock);
    end
    for (int n = 0; n < 50 && !accepted; n++) begin
      @(negedge clock);
      if (bus.HostReady) begin
        @(posedge clock); #2;
        accepted = 1'b1;
        accCyc   = cyc;
      end
    end
    bus.HostValid = 1'b0;
    checkOutput("hostAccept", word_t'(accepted), word_t'(1));
  endtask

  task automatic waitDone(input string tag, input int budget);
    bit done;
    done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      @(posedge clock); #2;
      done = (expCmdQ.size() == 0) && (expBeatQ.size() == 0) && (expRespQ.size() == 0) && bus.HostReady;
    end
    checkOutput(tag, word_t'(done), word_t'(1));
  endtask

  task automatic checkQuiet(input string tag, input logic hostReadyExp);
    checkOutput(tag, word_t'({bus.HostReady, bus.CmdValid, bus.DataInValid, bus.DataOutReady, bus.HostRespValid}),
                word_t'({hostReadyExp, 4'b0000}));
  endtask

  function automatic logic [ORAMB-1:0] randomBlock();
    logic [ORAMB-1:0] b;
    b = '0;
    for (int i = 0; i < ORAMB / 32; i++) b = (b << 32) | ORAMB'($urandom());
    return b;
  endfunction

  initial begin : watchdog
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int acc, lat, hsStart, n;
    logic [ORAMB-1:0] payload;

    bus.HostCmd   = '0;
    bus.HostAddr  = '0;
    bus.HostData  = '0;
    bus.HostValid = 1'b0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    checkQuiet("resetOutputs", 1'b0);
    checkOutput("resetRespData", word_t'(bus.HostRespData), word_t'(0));
    checkOutput("resetCmdAddr", word_t'({bus.Cmd, bus.PAddr}), word_t'(0));
    @(posedge clock); #2;
    reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    checkOutput("readyAfterReset", word_t'(bus.HostReady), word_t'(1));

    $display("[TB] write without backpressure");
    payload = '0;
    for (int i = 0; i < ORAMB / 8; i++) payload = payload | (ORAMB'(i) << (8 * i));
    applyStimulus(2'b00, 32'h1234, payload, acc);
    lat = -1;
    for (n = 0; n < 40 && lat < 0; n++) begin
      @(negedge clock);
      if (bus.HostReady) lat = cyc + 1 - acc;
    end
    checkOutput("writeTurnaround", word_t'(lat), word_t'(10));
    waitDone("writeDone", 50);

    $display("[TB] read with command stall, gapped beats, response stall");
    coreBlock = '0;
    for (int k = 0; k < NBeats; k++) coreBlock = coreBlock | (ORAMB'((k + 1) * 17) << (k * FEDWidth));
    outIdx = 0; gapOut = 1'b1; outEnable = 1'b1; cmdDelay = 5; respDelay = 3;
    applyStimulus(2'b11, 32'h7, randomBlock(), acc);
    waitDone("readStallDone", 100);
    outEnable = 1'b0; gapOut = 1'b0; cmdDelay = 0; respDelay = 0;

    $display("[TB] write with random DataInReady");
    dinRandom = 1'b1;
    for (int t = 0; t < 2; t++) begin
      hsStart = dinHsCount;
      applyStimulus(2'b01, $urandom(), randomBlock(), acc);
      waitDone("writeBpDone", 200);
      checkOutput("writeBpHandshakes", word_t'(dinHsCount - hsStart), word_t'(NBeats));
    end
    dinRandom = 1'b0;

    $display("[TB] reset in the middle of a write");
    hsStart = dinHsCount;
    applyStimulus(2'b00, 32'hABC, randomBlock(), acc);
    for (n = 0; n < 50 && (dinHsCount - hsStart) < 4; n++) begin
      @(posedge clock); #2;
    end
    reset = 1'b1;
    expBeatQ.delete();
    @(posedge clock); #2;
    reset = 1'b0;
    @(negedge clock);
    checkQuiet("midWriteReset", 1'b0);
    @(negedge clock);
    checkOutput("midWriteReady", word_t'(bus.HostReady), word_t'(1));

    $display("[TB] reset in the middle of a read");
    coreBlock = randomBlock();
    outIdx = 0; outEnable = 1'b1;
    applyStimulus(2'b10, 32'h99, randomBlock(), acc);
    for (n = 0; n < 50 && outIdx < 6; n++) begin
      @(posedge clock); #2;
    end
    checkOutput("midReadBeats", word_t'(outIdx), word_t'(6));
    reset = 1'b1;
    outEnable = 1'b0;
    expRespQ.delete();
    @(posedge clock); #2;
    reset = 1'b0;
    @(negedge clock);
    checkQuiet("midReadReset", 1'b0);
    @(negedge clock);
    checkOutput("midReadReady", word_t'(bus.HostReady), word_t'(1));

    coreBlock = randomBlock();
    @(posedge clock); #2;
    outIdx = 0; outEnable = 1'b1;
    applyStimulus(2'b10, 32'h100, randomBlock(), acc);
    waitDone("readAfterReset", 100);
    outEnable = 1'b0;

    $display("[TB] core output isolation outside a read");
    coreBlock = randomBlock();
    @(posedge clock); #2;
    outIdx = 0; outEnable = 1'b1;
    repeat (3) @(negedge clock);
    checkOutput("isoIdleReady", word_t'({bus.DataOutValid, bus.DataOutReady}), word_t'(2'b10));
    applyStimulus(2'b00, 32'h55, randomBlock(), acc);
    waitDone("isoWriteDone", 50);
    checkOutput("isoWriteNoConsume", word_t'(outIdx), word_t'(0));
    applyStimulus(2'b10, 32'h56, randomBlock(), acc);
    waitDone("isoReadDone", 100);
    outEnable = 1'b0;

    repeat (3) @(posedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end
endmodule
